// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared writeback definitions: geometry constants, the writeback packet
// layout seen by execution units and the scoreboard, and small helpers.
package vx_writeback_arbiter_pkg;

    localparam int NUM_THREADS   = 4;
    localparam int XLEN          = 32;
    localparam int UUID_WIDTH    = 44;
    localparam int NR_BITS       = 6;
    localparam int ISSUE_WIS_W   = 2;
    localparam int PERF_CTR_BITS = 44;
    localparam int STALL_TIMEOUT = 4096;
    localparam int DATAW_DEF     = NUM_THREADS * XLEN;

    // One writeback beat; multi-beat results are framed by sop/eop.
    typedef struct packed {
        logic [UUID_WIDTH-1:0]  uuid;
        logic [ISSUE_WIS_W-1:0] wis;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic [NR_BITS-1:0]     rd;
        logic [DATAW_DEF-1:0]   data;
        logic                   sop;
        logic                   eop;
    } wb_packet_t;

    // Lock state of the arbiter: free to rotate, or pinned to one unit.
    typedef enum logic [0:0] {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Saturating increment for performance counters (sticks at all-ones).
    function automatic logic [PERF_CTR_BITS-1:0] sat_inc(input logic [PERF_CTR_BITS-1:0] v);
        logic [PERF_CTR_BITS-1:0] r;
        r = (&v) ? v : (v + PERF_CTR_BITS'(1));
        return r;
    endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin arbiter with an instruction lock: once a unit's first
// non-final beat is accepted, only that unit may be granted until its eop.
module vx_rr_lock_arbiter
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_UNITS-1:0] req,
    input  logic [NUM_UNITS-1:0] eop,
    output logic [NUM_UNITS-1:0] grant,
    output logic                 locked
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    lock_state_e          lock_state_r, lock_state_n;
    logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_n;
    logic [PTR_W-1:0]     lock_id_r, lock_id_n;
    logic [NUM_UNITS-1:0] grant_s;
    logic [NUM_UNITS-1:0] lock_mask_s;
    logic [NUM_UNITS-1:0] accept_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic                 win_eop_s;
    logic [PTR_W:0]       ptr_inc_s;
    logic [PTR_W-1:0]     ptr_next_s;

    // First requester at or after ptr, wrapping; returns a one-hot vector.
    function automatic logic [NUM_UNITS-1:0] rr_pick(input logic [NUM_UNITS-1:0] r,
                                                     input logic [PTR_W-1:0]     ptr);
        logic [NUM_UNITS-1:0] pick;
        logic                 hit;
        logic [PTR_W:0]       pos;
        pick = '0;
        hit  = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(i);
            pos = (pos >= (PTR_W+1)'(NUM_UNITS)) ? (pos - (PTR_W+1)'(NUM_UNITS)) : pos;
            for (int j = 0; j < NUM_UNITS; j++) begin
                pick[j] = pick[j] | ((pos == (PTR_W+1)'(j)) & r[j] & ~hit);
            end
            hit = |pick;
        end
        return pick;
    endfunction

    // One-hot mask of the unit currently owning the lock
    always_comb begin
        lock_mask_s = '0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            lock_mask_s[j] = (lock_id_r == PTR_W'(j));
        end
    end

    // Grant: lock owner only while locked, otherwise rotating priority
    always_comb begin
        grant_s = '0;
        if (NUM_UNITS == 1) begin
            grant_s = '1;
        end else begin
            case (lock_state_r)
                LOCK_IDLE: grant_s = rr_pick(req, rr_ptr_r);
                LOCK_HELD: grant_s = req & lock_mask_s;
                default:   grant_s = '0;
            endcase
        end
    end

    assign accept_s = grant_s & req;

    // Encode the accepted unit and its successor for the pointer update
    always_comb begin
        win_idx_s = '0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            win_idx_s = win_idx_s | ({PTR_W{accept_s[j]}} & PTR_W'(j));
        end
        win_eop_s  = |(accept_s & eop);
        ptr_inc_s  = {1'b0, win_idx_s} + (PTR_W+1)'(1);
        ptr_next_s = (ptr_inc_s >= (PTR_W+1)'(NUM_UNITS)) ? '0 : ptr_inc_s[PTR_W-1:0];
    end

    // Next lock state: eop releases and advances pointer, non-eop pins winner
    always_comb begin
        lock_state_n = lock_state_r;
        lock_id_n    = lock_id_r;
        rr_ptr_n     = rr_ptr_r;
        if (NUM_UNITS == 1) begin
            lock_state_n = LOCK_IDLE;
            lock_id_n    = '0;
            rr_ptr_n     = '0;
        end else if (accept_s != '0) begin
            if (win_eop_s) begin
                lock_state_n = LOCK_IDLE;
                rr_ptr_n     = ptr_next_s;
            end else begin
                lock_state_n = LOCK_HELD;
                lock_id_n    = win_idx_s;
            end
        end else begin
            lock_state_n = lock_state_r;
        end
    end

    // Pointer and lock registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_r <= LOCK_IDLE;
            lock_id_r    <= '0;
            rr_ptr_r     <= '0;
        end else begin
            lock_state_r <= lock_state_n;
            lock_id_r    <= lock_id_n;
            rr_ptr_r     <= rr_ptr_n;
        end
    end

    assign grant  = grant_s;
    assign locked = (lock_state_r == LOCK_HELD);

endmodule

// File: rtl/vx_writeback_arbiter_chk.sv
// Protocol checker for the writeback arbiter: instruction framing must
// respect the grant lock, and no lock may be held indefinitely.
module vx_writeback_arbiter_chk
    import vx_writeback_arbiter_pkg::*;
(
    input logic clk,
    input logic reset,
    input logic acc_valid,
    input logic acc_sop,
    input logic locked
);

    logic [31:0] lock_cycles_r;

    // Length of the current lock episode in cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cycles_r <= 32'd0;
        end else if (locked) begin
            lock_cycles_r <= lock_cycles_r + 32'd1;
        end else begin
            lock_cycles_r <= 32'd0;
        end
    end

    a_sop_only_unlocked : assert property (@(posedge clk) disable iff (reset)
        (acc_valid && acc_sop) |-> !locked);

    a_locked_next_not_sop : assert property (@(posedge clk) disable iff (reset)
        (locked && acc_valid) |-> !acc_sop);

    a_lock_timeout : assert property (@(posedge clk) disable iff (reset)
        lock_cycles_r < 32'(STALL_TIMEOUT));

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Per-issue-slice writeback arbiter: merges execution-unit results into one
// registered writeback stream, keeping multi-beat instructions contiguous.
module vx_writeback_arbiter
    import vx_writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int DATAW       = DATAW_DEF,
    parameter int WIS_W       = ISSUE_WIS_W,
    parameter bit PERF_ENABLE = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_UNITS-1:0]                  unit_valid,
    output logic [NUM_UNITS-1:0]                  unit_ready,
    input  logic [NUM_UNITS-1:0][UUID_WIDTH-1:0]  unit_uuid,
    input  logic [NUM_UNITS-1:0][WIS_W-1:0]       unit_wis,
    input  logic [NUM_UNITS-1:0][NUM_THREADS-1:0] unit_tmask,
    input  logic [NUM_UNITS-1:0][XLEN-1:0]        unit_pc,
    input  logic [NUM_UNITS-1:0][NR_BITS-1:0]     unit_rd,
    input  logic [NUM_UNITS-1:0][DATAW-1:0]       unit_data,
    input  logic [NUM_UNITS-1:0]                  unit_sop,
    input  logic [NUM_UNITS-1:0]                  unit_eop,
    output logic                                  wb_valid,
    output logic [UUID_WIDTH-1:0]                 wb_uuid,
    output logic [WIS_W-1:0]                      wb_wis,
    output logic [NUM_THREADS-1:0]                wb_tmask,
    output logic [XLEN-1:0]                       wb_pc,
    output logic [NR_BITS-1:0]                    wb_rd,
    output logic [DATAW-1:0]                      wb_data,
    output logic                                  wb_sop,
    output logic                                  wb_eop,
    output logic [PERF_CTR_BITS-1:0]              perf_conflicts
);

    logic [NUM_UNITS-1:0]   grant_s;
    logic [NUM_UNITS-1:0]   accept_s;
    logic                   accept_any_s;
    logic                   conflict_s;
    logic                   locked_s;

    logic [UUID_WIDTH-1:0]  sel_uuid_s;
    logic [WIS_W-1:0]       sel_wis_s;
    logic [NUM_THREADS-1:0] sel_tmask_s;
    logic [XLEN-1:0]        sel_pc_s;
    logic [NR_BITS-1:0]     sel_rd_s;
    logic [DATAW-1:0]       sel_data_s;
    logic                   sel_sop_s;
    logic                   sel_eop_s;

    logic                   wb_valid_r;
    logic [UUID_WIDTH-1:0]  wb_uuid_r;
    logic [WIS_W-1:0]       wb_wis_r;
    logic [NUM_THREADS-1:0] wb_tmask_r;
    logic [XLEN-1:0]        wb_pc_r;
    logic [NR_BITS-1:0]     wb_rd_r;
    logic [DATAW-1:0]       wb_data_r;
    logic                   wb_sop_r;
    logic                   wb_eop_r;

    vx_rr_lock_arbiter #(
        .NUM_UNITS (NUM_UNITS)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (unit_valid),
        .eop    (unit_eop),
        .grant  (grant_s),
        .locked (locked_s)
    );

    // The output never stalls, so every grant is an acceptance.
    assign unit_ready   = grant_s;
    assign accept_s     = grant_s & unit_valid;
    assign accept_any_s = |accept_s;
    assign conflict_s   = |(unit_valid & ~grant_s);

    // One-hot AND-OR mux of the accepted unit's packet fields
    always_comb begin
        sel_uuid_s  = '0;
        sel_wis_s   = '0;
        sel_tmask_s = '0;
        sel_pc_s    = '0;
        sel_rd_s    = '0;
        sel_data_s  = '0;
        sel_sop_s   = 1'b0;
        sel_eop_s   = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_uuid_s  = sel_uuid_s  | (unit_uuid[k]  & {UUID_WIDTH{accept_s[k]}});
            sel_wis_s   = sel_wis_s   | (unit_wis[k]   & {WIS_W{accept_s[k]}});
            sel_tmask_s = sel_tmask_s | (unit_tmask[k] & {NUM_THREADS{accept_s[k]}});
            sel_pc_s    = sel_pc_s    | (unit_pc[k]    & {XLEN{accept_s[k]}});
            sel_rd_s    = sel_rd_s    | (unit_rd[k]    & {NR_BITS{accept_s[k]}});
            sel_data_s  = sel_data_s  | (unit_data[k]  & {DATAW{accept_s[k]}});
            sel_sop_s   = sel_sop_s   | (unit_sop[k]   & accept_s[k]);
            sel_eop_s   = sel_eop_s   | (unit_eop[k]   & accept_s[k]);
        end
    end

    // Writeback strobe: one cycle after each acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= accept_any_s;
        end
    end

    // Writeback payload: captured on acceptance, not reset (qualified by wb_valid)
    always_ff @(posedge clk) begin
        if (accept_any_s) begin
            wb_uuid_r  <= sel_uuid_s;
            wb_wis_r   <= sel_wis_s;
            wb_tmask_r <= sel_tmask_s;
            wb_pc_r    <= sel_pc_s;
            wb_rd_r    <= sel_rd_s;
            wb_data_r  <= sel_data_s;
            wb_sop_r   <= sel_sop_s;
            wb_eop_r   <= sel_eop_s;
        end
    end

    assign wb_valid = wb_valid_r;
    assign wb_uuid  = wb_uuid_r;
    assign wb_wis   = wb_wis_r;
    assign wb_tmask = wb_tmask_r;
    assign wb_pc    = wb_pc_r;
    assign wb_rd    = wb_rd_r;
    assign wb_data  = wb_data_r;
    assign wb_sop   = wb_sop_r;
    assign wb_eop   = wb_eop_r;

    generate
        if (PERF_ENABLE) begin : g_perf
            logic [PERF_CTR_BITS-1:0] perf_conflicts_r;

            // Count cycles where at least one offered packet is held back
            always_ff @(posedge clk) begin
                if (reset) begin
                    perf_conflicts_r <= '0;
                end else if (conflict_s) begin
                    perf_conflicts_r <= sat_inc(perf_conflicts_r);
                end
            end

            assign perf_conflicts = perf_conflicts_r;
        end else begin : g_no_perf
            assign perf_conflicts = '0;
        end
    endgenerate

`ifndef SYNTHESIS
    vx_writeback_arbiter_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (accept_any_s),
        .acc_sop   (sel_sop_s),
        .locked    (locked_s)
    );
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based reference model of the writeback arbitration rules.
module tb_vx_writeback_arbiter;
    import vx_writeback_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = DATAW_DEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-unit instance signals
    logic [N-1:0]                  unit_valid, unit_ready, unit_sop, unit_eop;
    logic [N-1:0][UUID_WIDTH-1:0]  unit_uuid;
    logic [N-1:0][ISSUE_WIS_W-1:0] unit_wis;
    logic [N-1:0][NUM_THREADS-1:0] unit_tmask;
    logic [N-1:0][XLEN-1:0]        unit_pc;
    logic [N-1:0][NR_BITS-1:0]     unit_rd;
    logic [N-1:0][DW-1:0]          unit_data;
    logic                          wb_valid, wb_sop, wb_eop;
    logic [UUID_WIDTH-1:0]         wb_uuid;
    logic [ISSUE_WIS_W-1:0]        wb_wis;
    logic [NUM_THREADS-1:0]        wb_tmask;
    logic [XLEN-1:0]               wb_pc;
    logic [NR_BITS-1:0]            wb_rd;
    logic [DW-1:0]                 wb_data;
    logic [PERF_CTR_BITS-1:0]      perf_conflicts;

    // 1-unit instance signals
    logic [0:0]                    s1_valid, s1_ready, s1_sop, s1_eop;
    logic [0:0][UUID_WIDTH-1:0]    s1_uuid;
    logic [0:0][ISSUE_WIS_W-1:0]   s1_wis;
    logic [0:0][NUM_THREADS-1:0]   s1_tmask;
    logic [0:0][XLEN-1:0]          s1_pc;
    logic [0:0][NR_BITS-1:0]       s1_rd;
    logic [0:0][DW-1:0]            s1_data;
    logic                          s1_wb_valid, s1_wb_sop, s1_wb_eop;
    logic [UUID_WIDTH-1:0]         s1_wb_uuid;
    logic [ISSUE_WIS_W-1:0]        s1_wb_wis;
    logic [NUM_THREADS-1:0]        s1_wb_tmask;
    logic [XLEN-1:0]               s1_wb_pc;
    logic [NR_BITS-1:0]            s1_wb_rd;
    logic [DW-1:0]                 s1_wb_data;
    logic [PERF_CTR_BITS-1:0]      s1_perf;

    vx_writeback_arbiter #(.NUM_UNITS(N)) dut (
        .clk(clk), .reset(reset),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_uuid(unit_uuid),
        .unit_wis(unit_wis), .unit_tmask(unit_tmask), .unit_pc(unit_pc),
        .unit_rd(unit_rd), .unit_data(unit_data), .unit_sop(unit_sop), .unit_eop(unit_eop),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wis(wb_wis), .wb_tmask(wb_tmask),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop), .wb_eop(wb_eop),
        .perf_conflicts(perf_conflicts)
    );

    vx_writeback_arbiter #(.NUM_UNITS(1)) dut1 (
        .clk(clk), .reset(reset),
        .unit_valid(s1_valid), .unit_ready(s1_ready), .unit_uuid(s1_uuid),
        .unit_wis(s1_wis), .unit_tmask(s1_tmask), .unit_pc(s1_pc),
        .unit_rd(s1_rd), .unit_data(s1_data), .unit_sop(s1_sop), .unit_eop(s1_eop),
        .wb_valid(s1_wb_valid), .wb_uuid(s1_wb_uuid), .wb_wis(s1_wb_wis), .wb_tmask(s1_wb_tmask),
        .wb_pc(s1_wb_pc), .wb_rd(s1_wb_rd), .wb_data(s1_wb_data), .wb_sop(s1_wb_sop),
        .wb_eop(s1_wb_eop), .perf_conflicts(s1_perf)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus state: per-unit queue of pending beats
    wb_packet_t            pend_q [N][$];
    logic [N-1:0]          en;
    int                    off_cnt [N];
    int                    bubble_pct;
    bit                    auto_refill;
    logic [UUID_WIDTH-1:0] uuid_ctr;

    // Reference model state
    int                       m_ptr;
    bit                       m_locked;
    int                       m_lock_id;
    logic [PERF_CTR_BITS-1:0] m_perf;
    bit                       exp_valid;
    wb_packet_t               exp_pkt;
    int                       served [$];
    logic [N-1:0]             last_ready;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic wb_packet_t make_pkt(input logic [UUID_WIDTH-1:0] uuid,
                                            input logic [NR_BITS-1:0] rd,
                                            input logic [ISSUE_WIS_W-1:0] wis,
                                            input logic sop, input logic eop);
        wb_packet_t p;
        p.uuid  = uuid;
        p.rd    = rd;
        p.wis   = wis;
        p.tmask = NUM_THREADS'($urandom);
        p.pc    = XLEN'($urandom);
        p.data  = DW'({$urandom, $urandom, $urandom, $urandom});
        p.sop   = sop;
        p.eop   = eop;
        return p;
    endfunction

    task automatic push_instr(input int k, input int len, input logic [NR_BITS-1:0] rd,
                              input logic [ISSUE_WIS_W-1:0] wis);
        for (int i = 0; i < len; i++) begin
            pend_q[k].push_back(make_pkt(uuid_ctr, rd, wis, (i == 0), (i == len - 1)));
        end
        uuid_ctr = uuid_ctr + UUID_WIDTH'(1);
    endtask

    // Spec rule: locked -> only owner; else first valid scanning from pointer.
    function automatic int model_winner(input logic [N-1:0] v);
        if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
        for (int i = 0; i < N; i++) begin
            if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_units();
        wb_packet_t p;
        for (int k = 0; k < N; k++) begin
            if (auto_refill && pend_q[k].size() == 0)
                push_instr(k, $urandom_range(1, 3), NR_BITS'($urandom), ISSUE_WIS_W'($urandom));
            if (en[k] && off_cnt[k] == 0 && pend_q[k].size() != 0 &&
                $urandom_range(0, 99) >= bubble_pct) begin
                unit_valid[k] = 1'b1;
                p = pend_q[k][0];
            end else begin
                unit_valid[k] = 1'b0;
                p = make_pkt(UUID_WIDTH'({$urandom, $urandom}), NR_BITS'($urandom),
                             ISSUE_WIS_W'($urandom), 1'($urandom), 1'($urandom));
            end
            unit_uuid[k]  = p.uuid;
            unit_wis[k]   = p.wis;
            unit_tmask[k] = p.tmask;
            unit_pc[k]    = p.pc;
            unit_rd[k]    = p.rd;
            unit_data[k]  = p.data;
            unit_sop[k]   = p.sop;
            unit_eop[k]   = p.eop;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        unit_valid = '0;
        for (int k = 0; k < N; k++) begin
            pend_q[k].delete();
            off_cnt[k] = 0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0; m_locked = 0; m_lock_id = 0; m_perf = '0; exp_valid = 0;
        served.delete();
        drive_units();
    endtask

    // One clock: compare DUT against model, then advance model and stimulus.
    task automatic step();
        logic [N-1:0] v, g;
        int w;
        @(negedge clk);
        v = unit_valid;
        w = model_winner(v);
        g = '0;
        if (w >= 0) g[w] = 1'b1;
        last_ready = unit_ready;
        check_eq("unit_ready", unit_ready, g);
        check_eq("wb_valid", wb_valid, exp_valid);
        if (exp_valid) begin
            check_eq("wb_uuid", wb_uuid, exp_pkt.uuid);
            check_eq("wb_wis", wb_wis, exp_pkt.wis);
            check_eq("wb_tmask", wb_tmask, exp_pkt.tmask);
            check_eq("wb_pc", wb_pc, exp_pkt.pc);
            check_eq("wb_rd", wb_rd, exp_pkt.rd);
            check_eq("wb_data", wb_data, exp_pkt.data);
            check_eq("wb_sop", wb_sop, exp_pkt.sop);
            check_eq("wb_eop", wb_eop, exp_pkt.eop);
        end
        check_eq("perf_conflicts", perf_conflicts, m_perf);
        if ((v & ~g) != '0 && m_perf != '1) m_perf = m_perf + 1'b1;
        exp_valid = (w >= 0);
        if (w >= 0) begin
            exp_pkt = pend_q[w].pop_front();
            served.push_back(w);
            if (exp_pkt.eop) begin
                m_locked = 0;
                m_ptr    = (w + 1) % N;
            end else begin
                m_locked  = 1;
                m_lock_id = w;
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) if (off_cnt[k] > 0) off_cnt[k]--;
        drive_units();
    endtask

    initial begin
        wb_packet_t sp, s1_exp;
        bit         s1_exp_valid;
        int         sent;

        reset = 1'b1;
        en = '1; bubble_pct = 0; auto_refill = 0; uuid_ctr = '0;
        for (int k = 0; k < N; k++) off_cnt[k] = 0;
        s1_valid = '0; s1_uuid = '0; s1_wis = '0; s1_tmask = '0; s1_pc = '0;
        s1_rd = '0; s1_data = '0; s1_sop = '0; s1_eop = '0;
        @(posedge clk); #1;

        // Idle after reset
        do_reset();
        repeat (10) step();

        // Units 0 and 2 with single-beat results alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_instr(0, 1, NR_BITS'(10), ISSUE_WIS_W'(0));
            push_instr(2, 1, NR_BITS'(12), ISSUE_WIS_W'(1));
        end
        drive_units();
        repeat (13) step();
        check_eq("alt_count", served.size(), 12);
        for (int i = 0; i < served.size(); i++) check_eq("alt_order", served[i], (i % 2 == 0) ? 0 : 2);

        // Three-beat instruction on unit 1 holds off unit 3
        do_reset();
        push_instr(1, 3, NR_BITS'(5), ISSUE_WIS_W'(2));
        push_instr(3, 1, NR_BITS'(7), ISSUE_WIS_W'(3));
        drive_units();
        repeat (5) step();
        check_eq("lock_count", served.size(), 4);
        for (int i = 0; i < served.size(); i++) check_eq("lock_order", served[i], (i < 3) ? 1 : 3);

        // Owner drops valid for two cycles mid-instruction; unit 0 stays blocked
        do_reset();
        en = 4'b0010;
        push_instr(1, 3, NR_BITS'(5), ISSUE_WIS_W'(2));
        push_instr(0, 1, NR_BITS'(9), ISSUE_WIS_W'(0));
        drive_units();
        step();
        en = 4'b0011;
        off_cnt[1] = 2;
        drive_units();
        step();
        check_eq("gap_ready", last_ready, 4'b0000);
        step();
        repeat (4) step();
        check_eq("gap_count", served.size(), 4);
        for (int i = 0; i < served.size(); i++) check_eq("gap_order", served[i], (i < 3) ? 1 : 0);
        en = '1;

        // Reset while locked on unit 2
        do_reset();
        push_instr(2, 3, NR_BITS'(3), ISSUE_WIS_W'(1));
        drive_units();
        step();
        push_instr(0, 1, NR_BITS'(4), ISSUE_WIS_W'(0));
        drive_units();
        step();
        do_reset();
        push_instr(0, 1, NR_BITS'(4), ISSUE_WIS_W'(0));
        push_instr(2, 1, NR_BITS'(3), ISSUE_WIS_W'(1));
        drive_units();
        step();
        check_eq("rst_first_ready", last_ready, 4'b0001);
        check_eq("rst_served_n", served.size(), 1);
        if (served.size() > 0) check_eq("rst_first_winner", served[0], 0);
        repeat (3) step();

        // Randomized traffic with bubbles, then drain
        do_reset();
        auto_refill = 1; bubble_pct = 25;
        drive_units();
        repeat (1500) step();
        auto_refill = 0; bubble_pct = 0;
        drive_units();
        repeat (30) step();

        // Single-unit build: always ready, one-cycle latency, exact fields
        en = '0;
        drive_units();
        sent = 0; s1_exp_valid = 0;
        s1_exp = make_pkt('0, '0, '0, 1'b0, 1'b0);
        while (sent < 20 || s1_exp_valid) begin
            sp = make_pkt(UUID_WIDTH'({$urandom, $urandom}), NR_BITS'($urandom),
                          ISSUE_WIS_W'($urandom), 1'($urandom), 1'($urandom));
            s1_valid[0] = (sent < 20) && ($urandom_range(0, 3) != 0);
            s1_uuid[0] = sp.uuid; s1_wis[0] = sp.wis; s1_tmask[0] = sp.tmask;
            s1_pc[0] = sp.pc; s1_rd[0] = sp.rd; s1_data[0] = sp.data;
            s1_sop[0] = sp.sop; s1_eop[0] = sp.eop;
            @(negedge clk);
            check_eq("s1_ready", s1_ready, 1'b1);
            check_eq("s1_wb_valid", s1_wb_valid, s1_exp_valid);
            if (s1_exp_valid) begin
                check_eq("s1_wb_uuid", s1_wb_uuid, s1_exp.uuid);
                check_eq("s1_wb_wis", s1_wb_wis, s1_exp.wis);
                check_eq("s1_wb_tmask", s1_wb_tmask, s1_exp.tmask);
                check_eq("s1_wb_pc", s1_wb_pc, s1_exp.pc);
                check_eq("s1_wb_rd", s1_wb_rd, s1_exp.rd);
                check_eq("s1_wb_data", s1_wb_data, s1_exp.data);
                check_eq("s1_wb_sop", s1_wb_sop, s1_exp.sop);
                check_eq("s1_wb_eop", s1_wb_eop, s1_exp.eop);
            end
            check_eq("s1_perf", s1_perf, '0);
            s1_exp_valid = s1_valid[0];
            s1_exp = sp;
            if (s1_valid[0]) sent++;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
